// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache: sync-read tag/data arrays, saturating age victim choice, burst line refill.
// Optional macro ICACHE_FENCE_I_EN enables fence_i invalidation (immediate in IDLE, deferred otherwise).
module i_cache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BEATS = 2,
  parameter int AGE_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_addr,
  input  logic        inst_req,
  output logic        inst_gnt,
  output logic [31:0] inst_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        cache_read_ena,
  output logic [63:0] cache_addr,
  input  logic [63:0] cache_or_data,
  input  logic        cache_in_ok,
  input  logic        cache_last,
  input  logic        fence_i
);
  localparam int OFF_W  = $clog2(LINE_BEATS * 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int TAG_W  = 64 - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int ROWS   = SETS * (2 ** BEAT_W);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] d, input logic sel);
    return sel ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [63:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(input logic [63:0] a);
    logic [BEAT_W-1:0] b;
    b = a[3 +: BEAT_W];
    if (LINE_BEATS == 1) b = '0;
    return b;
  endfunction

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, COMMIT, RESP} state_t;
  state_t state_q, state_d;

  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [63:0]      data_mem [WAYS][ROWS];
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [AGE_W-1:0] age_q    [SETS][WAYS];

  logic [63:0]      addr_p1;
  logic [TAG_W-1:0] rd_tag_p1  [WAYS];
  logic [63:0]      rd_data_p1 [WAYS];

  logic [IDX_W-1:0]  idx_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [BEAT_W-1:0] beat_p1;
  logic              word_p1;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              have_inv;
  logic [AGE_W-1:0]  best_age;

  logic [WAY_W-1:0]  victim_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              full_q;
  logic              ena_q;
  logic [63:0]       cache_addr_q;
  logic [31:0]       resp_data;
  logic              flush;

  assign idx_p1  = idx_of(addr_p1);
  assign tag_p1  = addr_p1[63 -: TAG_W];
  assign beat_p1 = beat_of(addr_p1);
  assign word_p1 = addr_p1[2];

  assign inst_valid     = (state_q == RESP);
  assign inst_data      = resp_data;
  assign cache_read_ena = ena_q;
  assign cache_addr     = cache_addr_q;

`ifdef ICACHE_FENCE_I_EN
  logic fence_pend_q;
  logic unused_bits;

  // A fence seen outside IDLE is remembered and drains on the next IDLE cycle.
  assign flush = (state_q == IDLE) && (fence_i || fence_pend_q);
  assign unused_bits = ^addr_p1[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fence_pend_q <= 1'b0;
    end else if (state_q == IDLE) begin
      fence_pend_q <= 1'b0;
    end else if (fence_i) begin
      fence_pend_q <= 1'b1;
    end
  end
`else
  logic unused_bits;

  assign flush = 1'b0;
  assign unused_bits = ^{fence_i, addr_p1[1:0]};
`endif

  // Stage p1 (LOOKUP): tag compare, lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx_p1][w] && (rd_tag_p1[w] == tag_p1)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim   = '0;
    have_inv = 1'b0;
    best_age = age_q[idx_p1][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!have_inv && !valid_q[idx_p1][w]) begin
        have_inv = 1'b1;
        victim   = WAY_W'(w);
      end
    end
    if (!have_inv) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[idx_p1][w] > best_age) begin
          best_age = age_q[idx_p1][w];
          victim   = WAY_W'(w);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    inst_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        inst_gnt = !rst && !flush;
        if (inst_req && inst_gnt) state_d = LOOKUP;
      end
      LOOKUP: state_d = hit ? RESP : REFILL;
      REFILL: if (cache_in_ok && cache_last) state_d = COMMIT;
      COMMIT: state_d = RESP;
      RESP:   if (inst_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ena_q        <= 1'b0;
      cache_addr_q <= '0;
      resp_data    <= '0;
      victim_q     <= '0;
      beat_cnt     <= '0;
      full_q       <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= '0;
              for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data <= word_of(rd_data_p1[hit_way], word_p1);
            for (int w = 0; w < WAYS; w++)
              age_q[idx_p1][w] <= (WAY_W'(w) == hit_way) ? '0 : sat_inc(age_q[idx_p1][w]);
          end else begin
            ena_q        <= 1'b1;
            cache_addr_q <= {addr_p1[63:OFF_W], {OFF_W{1'b0}}};
            victim_q     <= victim;
            beat_cnt     <= '0;
            full_q       <= 1'b0;
          end
        end
        // Stage p2 (REFILL): beats arrive in order; the requested word is captured as it passes.
        REFILL: begin
          if (cache_in_ok) begin
            ena_q    <= 1'b0;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == beat_p1) resp_data <= word_of(cache_or_data, word_p1);
            if (cache_last) full_q <= (beat_cnt == LAST_BEAT);
          end
        end
        COMMIT: begin
          if (full_q) begin
            valid_q[idx_p1][victim_q] <= 1'b1;
            for (int w = 0; w < WAYS; w++)
              age_q[idx_p1][w] <= (WAY_W'(w) == victim_q) ? '0 : sat_inc(age_q[idx_p1][w]);
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> p1: arrays are read with the raw fetch address in the grant cycle.
  always_ff @(posedge clk) begin
    if (inst_req && inst_gnt) begin
      addr_p1 <= inst_addr;
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_p1[w]  <= tag_mem[w][idx_of(inst_addr)];
        rd_data_p1[w] <= data_mem[w][{idx_of(inst_addr), beat_of(inst_addr)}];
      end
    end
    if (state_q == REFILL && cache_in_ok)
      data_mem[victim_q][{idx_p1, beat_cnt}] <= cache_or_data;
    if (state_q == COMMIT && full_q)
      tag_mem[victim_q][idx_p1] <= tag_p1;
  end

endmodule

// File: tb/tb_i_cache_nway.sv
// Bench for i_cache_nway: directed vector table, multi-cycle corner sequences, and random fetches vs a set/way model.
module tb_i_cache_nway;
  localparam int WAYS    = 2;
  localparam int SETS    = 64;
  localparam int LB      = 2;
  localparam int AGE_W   = 3;
  localparam int AGE_MAX = (1 << AGE_W) - 1;
  localparam int LINE_B  = LB * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inst_addr = '0;
  logic        inst_req = 1'b0;
  logic        inst_gnt;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [63:0] cache_or_data = '0;
  logic        cache_in_ok = 1'b0;
  logic        cache_last = 1'b0;
  logic        fence_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  i_cache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BEATS(LB), .AGE_W(AGE_W)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_req(inst_req), .inst_gnt(inst_gnt),
    .inst_data(inst_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .cache_read_ena(cache_read_ena), .cache_addr(cache_addr), .cache_or_data(cache_or_data),
    .cache_in_ok(cache_in_ok), .cache_last(cache_last), .fence_i(fence_i)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Backing memory: each 64-bit beat holds an address-derived pattern.
  function automatic logic [63:0] mem64(input logic [63:0] a);
    logic [31:0] b;
    b = a[31:0] & 32'hFFFF_FFF8;
    return {b ^ 32'h5A5A_0F0F, (b >> 3) + 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    logic [63:0] d;
    d = mem64(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  // Reference: each set is a list of ways holding a line number, a valid flag and an age.
  bit          mv   [SETS][WAYS];
  logic [63:0] ml   [SETS][WAYS];
  int          mage [SETS][WAYS];

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0; ml[s][w] = '0; mage[s][w] = 0;
      end
  endfunction

  function automatic bit model_access(input logic [63:0] a);
    logic [63:0] line;
    int s, hw;
    bit miss;
    line = a / 64'(LINE_B);
    s = int'(line % 64'(SETS));
    hw = -1;
    miss = 0;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && mv[s][w] && ml[s][w] == line) hw = w;
    if (hw < 0) begin
      miss = 1;
      for (int w = 0; w < WAYS; w++)
        if (hw < 0 && !mv[s][w]) hw = w;
      if (hw < 0) begin
        hw = 0;
        for (int w = 1; w < WAYS; w++)
          if (mage[s][w] > mage[s][hw]) hw = w;
      end
      mv[s][hw] = 1;
      ml[s][hw] = line;
    end
    for (int w = 0; w < WAYS; w++)
      mage[s][w] = (w == hw) ? 0 : ((mage[s][w] < AGE_MAX) ? mage[s][w] + 1 : AGE_MAX);
    return miss;
  endfunction

  // One complete fetch; entered and left on a negedge with the DUT in IDLE.
  task automatic fetch(input logic [63:0] a, input int hold, input int gap, input bit early,
                       output bit missed, output logic [63:0] baddr, output logic [31:0] data);
    int n;
    bit lastb;
    missed = 1'b0;
    baddr = '0;
    data = '0;
    inst_addr = a;
    inst_req = 1'b1;
    n = 0;
    while (!inst_gnt && n < 8) begin @(negedge clk); n++; end
    if (!inst_gnt) begin
      check("gnt_timeout", inst_gnt, 1);
      inst_req = 1'b0;
      return;
    end
    @(negedge clk);
    inst_req = 1'b0;
    inst_addr = ~a;
    n = 0;
    while (!inst_valid && !cache_read_ena && n < 8) begin @(negedge clk); n++; end
    if (cache_read_ena) begin
      missed = 1'b1;
      baddr = cache_addr;
      for (int b = 0; b < LB; b++) begin
        for (int g = 0; g < gap; g++) @(negedge clk);
        lastb = early || (b == LB - 1);
        cache_in_ok = 1'b1;
        cache_or_data = mem64(baddr + 64'(b * 8));
        cache_last = lastb;
        @(negedge clk);
        cache_in_ok = 1'b0;
        cache_last = 1'b0;
        if (b == 0) check("ena_drop", cache_read_ena, 0);
        if (!lastb) check("addr_stable", cache_addr, baddr);
        if (lastb) break;
      end
      n = 0;
      while (!inst_valid && n < 8) begin @(negedge clk); n++; end
      check("miss_latency", n, 1);
    end else begin
      check("hit_latency", n, 1);
    end
    if (!inst_valid) begin
      check("valid_timeout", inst_valid, 1);
      return;
    end
    data = inst_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_stable", {inst_valid, inst_gnt, inst_data}, {1'b1, 1'b0, data});
    end
    check("resp_no_gnt", inst_gnt, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("b2b_gnt", {inst_gnt, inst_valid}, 2'b10);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          hold;
    bit          exp_miss;
    logic [63:0] exp_baddr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit m, em;
    logic [63:0] ba, a;
    logic [31:0] d;
    int n;

    // A = 0x8000_0000, B = +0x400, C = +0x800 share set 0.
    tbl[0] = '{64'h8000_0004, 0, 1'b1, 64'h8000_0000, exp_word(64'h8000_0004)};
    tbl[1] = '{64'h8000_0000, 0, 1'b0, 64'h0,         exp_word(64'h8000_0000)};
    tbl[2] = '{64'h8000_0008, 5, 1'b0, 64'h0,         exp_word(64'h8000_0008)};
    tbl[3] = '{64'h8000_0400, 0, 1'b1, 64'h8000_0400, exp_word(64'h8000_0400)};
    tbl[4] = '{64'h8000_0004, 1, 1'b0, 64'h0,         exp_word(64'h8000_0004)};
    tbl[5] = '{64'h8000_080C, 0, 1'b1, 64'h8000_0800, exp_word(64'h8000_080C)};
    tbl[6] = '{64'h8000_0000, 0, 1'b0, 64'h0,         exp_word(64'h8000_0000)};
    tbl[7] = '{64'h8000_0404, 2, 1'b1, 64'h8000_0400, exp_word(64'h8000_0404)};
    tbl[8] = '{64'h8000_0800, 0, 1'b1, 64'h8000_0800, exp_word(64'h8000_0800)};
    tbl[9] = '{64'h8000_0400, 0, 1'b0, 64'h0,         exp_word(64'h8000_0400)};

    @(negedge clk);
    check("rst_ctl", {inst_gnt, inst_valid, cache_read_ena}, 3'b000);
    check("rst_data", inst_data, 0);
    check("rst_addr", cache_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_gnt", inst_gnt, 1);

    for (int i = 0; i < 10; i++) begin
      fetch(tbl[i].addr, tbl[i].hold, 0, 1'b0, m, ba, d);
      check($sformatf("t%0d_miss", i), m, tbl[i].exp_miss);
      if (tbl[i].exp_miss) check($sformatf("t%0d_baddr", i), ba, tbl[i].exp_baddr);
      check($sformatf("t%0d_data", i), d, tbl[i].exp_data);
    end

    // fence_i pulse in IDLE, then re-fetch B (resident before the pulse).
    fence_i = 1'b1;
`ifdef ICACHE_FENCE_I_EN
    check("fence_gnt", inst_gnt, 0);
`else
    check("fence_gnt", inst_gnt, 1);
`endif
    @(negedge clk);
    fence_i = 1'b0;
    fetch(64'h8000_0400, 0, 0, 1'b0, m, ba, d);
`ifdef ICACHE_FENCE_I_EN
    check("fence_refetch_miss", m, 1);
`else
    check("fence_refetch_miss", m, 0);
`endif
    check("fence_refetch_data", d, exp_word(64'h8000_0400));

    // Early cache_last: line stays invalid, response still returned.
    fetch(64'hA000_0018, 1, 0, 1'b1, m, ba, d);
    check("el_miss", m, 1);
    check("el_baddr", ba, 64'hA000_0010);
    fetch(64'hA000_0014, 0, 1, 1'b0, m, ba, d);
    check("el_remiss", m, 1);
    check("el_data", d, exp_word(64'hA000_0014));
    fetch(64'hA000_0018, 0, 0, 1'b0, m, ba, d);
    check("el_hit", m, 0);
    check("el_hit_data", d, exp_word(64'hA000_0018));

    // Reset in the middle of a refill.
    inst_addr = 64'hB000_0000;
    inst_req = 1'b1;
    check("rm_gnt", inst_gnt, 1);
    @(negedge clk);
    inst_req = 1'b0;
    n = 0;
    while (!cache_read_ena && n < 8) begin @(negedge clk); n++; end
    check("rm_ena", cache_read_ena, 1);
    cache_in_ok = 1'b1;
    cache_or_data = mem64(64'hB000_0000);
    @(negedge clk);
    cache_in_ok = 1'b0;
    rst = 1'b1;
    #1;
    check("rm_ctl", {inst_gnt, inst_valid, cache_read_ena}, 3'b000);
    check("rm_data", inst_data, 0);
    check("rm_addr", cache_addr, 0);
    @(negedge clk);
    cache_in_ok = 1'b1;
    cache_last = 1'b1;
    cache_or_data = mem64(64'hB000_0008);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cache_in_ok = 1'b0;
    cache_last = 1'b0;
    check("rm_idle", {inst_gnt, inst_valid, cache_read_ena}, 3'b100);
    model_clear();
    em = model_access(64'h8000_0400);
    fetch(64'h8000_0400, 0, 0, 1'b0, m, ba, d);
    check("rm_refetch_miss", m, em);
    check("rm_refetch_data", d, exp_word(64'h8000_0400));

    // Random fetches over 4 tags x 4 sets to force conflicts and evictions.
    for (int i = 0; i < 200; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64'h400
                        + 64'($urandom_range(0, 3)) * 64'(LINE_B)
                        + 64'($urandom_range(0, LINE_B - 1));
      em = model_access(a);
      fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1'b0, m, ba, d);
      check($sformatf("rnd%0d_miss", i), m, em);
      if (em) check($sformatf("rnd%0d_baddr", i), ba, a & ~64'(LINE_B - 1));
      check($sformatf("rnd%0d_data", i), d, exp_word(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
